// File: rtl/exc_seq.sv
// Exception/return sequencer for decode: traps, drains the pipe, redirects PC; optional interrupt via EXC_IRQ_EN.
// Latency: trap -> pc_load after FLUSH_CYCLES+1 cycles; rfe -> pc_load next cycle; all outputs registered.
// Backpressure: stall blocks acceptance in RUN and freezes state, counter and outputs elsewhere.
module exc_seq #(
  parameter logic [31:0] VEC_BASE     = 32'h0000_0080,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  vector_id,
  input  logic [31:0] exc_pc,
  input  logic        rfe,
  input  logic        stall,
`ifdef EXC_IRQ_EN
  input  logic        irq,
`endif
  output logic        control_sel,
  output logic        flush,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic [31:0] epc,
  output logic [4:0]  cause,
  output logic        s_u,
  output logic        busy
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    $error("exc_seq: FLUSH_CYCLES must be 1..15");
  end

  typedef enum logic [1:0] {RUN, FLUSH, VECTOR, RETURN} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       saved_su;
  logic       take_irq;
  logic       take_exc;
  logic [4:0] new_cause;

`ifdef EXC_IRQ_EN
  logic ie;
  assign take_irq = irq & ie;
`else
  assign take_irq = 1'b0;
`endif

  // Synchronous exceptions always beat the interrupt and rfe.
  assign take_exc  = (vector_id != 5'd0) | take_irq;
  assign new_cause = (vector_id != 5'd0) ? vector_id : 5'h1F;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      cnt         <= 4'd0;
      s_u         <= 1'b0;
      saved_su    <= 1'b0;
      epc         <= 32'd0;
      cause       <= 5'd0;
      control_sel <= 1'b1;
      flush       <= 1'b0;
      pc_load     <= 1'b0;
      pc_target   <= 32'd0;
      busy        <= 1'b0;
`ifdef EXC_IRQ_EN
      ie          <= 1'b0;
`endif
    end else if (!stall) begin
      case (state)
        RUN: begin
          if (take_exc) begin
            epc         <= exc_pc;
            cause       <= new_cause;
            saved_su    <= s_u;
            s_u         <= 1'b0;
            cnt         <= CNT_INIT;
            state       <= FLUSH;
            control_sel <= 1'b0;
            flush       <= 1'b1;
            busy        <= 1'b1;
`ifdef EXC_IRQ_EN
            if (vector_id == 5'd0) ie <= 1'b0;
`endif
          end else if (rfe) begin
            state       <= RETURN;
            control_sel <= 1'b0;
            flush       <= 1'b1;
            busy        <= 1'b1;
            pc_load     <= 1'b1;
            pc_target   <= epc;
          end
        end
        FLUSH: begin
          if (cnt == 4'd0) begin
            state     <= VECTOR;
            pc_load   <= 1'b1;
            pc_target <= VEC_BASE + {22'd0, cause, 3'b000};
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        VECTOR: begin
          state       <= RUN;
          control_sel <= 1'b1;
          flush       <= 1'b0;
          busy        <= 1'b0;
          pc_load     <= 1'b0;
          pc_target   <= 32'd0;
        end
        RETURN: begin
          state       <= RUN;
          s_u         <= saved_su;
          control_sel <= 1'b1;
          flush       <= 1'b0;
          busy        <= 1'b0;
          pc_load     <= 1'b0;
          pc_target   <= 32'd0;
`ifdef EXC_IRQ_EN
          ie          <= 1'b1;
`endif
        end
        default: begin
          state       <= RUN;
          control_sel <= 1'b1;
          flush       <= 1'b0;
          busy        <= 1'b0;
          pc_load     <= 1'b0;
          pc_target   <= 32'd0;
        end
      endcase
    end
  end

endmodule
